// File: rtl/adc_speed_sampler.sv
// ADC0804-style conversion sequencer: one WR/INTR/RD handshake per adc_start rising edge,
// with a noise floor on the captured sample and a timeout if the ADC never signals completion.
module adc_speed_sampler #(
  parameter int unsigned WR_CYCLES      = 20,
  parameter int unsigned RD_CYCLES      = 20,
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned NOISE_FLOOR    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       adc_start,
  input  logic       player,
  input  logic [7:0] adc_data,
  input  logic       adc_intr_n,
  output logic       adc_cs_n,
  output logic       adc_wr_n,
  output logic       adc_rd_n,
  output logic       adc_mux_sel,
  output logic [7:0] moveSpeed,
  output logic       eoc,
  output logic       timeout
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WR, S_WAIT, S_RD, S_DONE} state_t;

  localparam logic [15:0] WR_LAST = 16'(WR_CYCLES - 1);
  localparam logic [15:0] RD_LAST = 16'(RD_CYCLES - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  NF      = 8'(NOISE_FLOOR);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  speed_q, speed_d;
  logic        cs_n_q, cs_n_d;
  logic        wr_n_q, wr_n_d;
  logic        rd_n_q, rd_n_d;
  logic        mux_q, mux_d;
  logic        eoc_q, eoc_d;
  logic        to_q, to_d;
  logic        start_q;
  logic        intr_s1_q, intr_s2_q;
  logic        req;

  assign req = adc_start & ~start_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      speed_q   <= '0;
      cs_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      mux_q     <= 1'b0;
      eoc_q     <= 1'b1;
      to_q      <= 1'b0;
      start_q   <= 1'b0;
      intr_s1_q <= 1'b1;
      intr_s2_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      speed_q   <= speed_d;
      cs_n_q    <= cs_n_d;
      wr_n_q    <= wr_n_d;
      rd_n_q    <= rd_n_d;
      mux_q     <= mux_d;
      eoc_q     <= eoc_d;
      to_q      <= to_d;
      start_q   <= adc_start;
      intr_s1_q <= adc_intr_n;
      intr_s2_q <= intr_s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    speed_d = speed_q;
    cs_n_d  = cs_n_q;
    wr_n_d  = wr_n_q;
    rd_n_d  = rd_n_q;
    mux_d   = mux_q;
    eoc_d   = eoc_q;
    to_d    = to_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          mux_d   = player;
          eoc_d   = 1'b0;
          to_d    = 1'b0;
          cs_n_d  = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        wr_n_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_WR;
      end
      S_WR: begin
        if (cnt_q == WR_LAST) begin
          wr_n_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        if (!intr_s2_q) begin
          rd_n_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_RD;
        end else if (cnt_q == TO_LAST) begin
          speed_d = '0;
          to_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RD: begin
        if (cnt_q == RD_LAST) begin
          data_d  = adc_data;
          rd_n_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        cs_n_d = 1'b1;
        // A timed-out conversion already zeroed moveSpeed in WAIT; data_q is stale then.
        if (!to_q) speed_d = (data_q < NF) ? '0 : data_q;
        eoc_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign adc_cs_n    = cs_n_q;
  assign adc_wr_n    = wr_n_q;
  assign adc_rd_n    = rd_n_q;
  assign adc_mux_sel = mux_q;
  assign moveSpeed   = speed_q;
  assign eoc         = eoc_q;
  assign timeout     = to_q;

endmodule
